// File: rtl/team_06_i2s_stereo_rx.sv
// Stereo I2S / left-justified receiver acting as bus master.
// Generates sck_o and ws_o for an external ADC, deserialises the left and
// right slots MSB-first, and presents one {left,right} frame on a
// valid/ready output port with a sticky overrun flag for dropped frames.
module team_06_i2s_stereo_rx #(
    parameter int CLK_DIV    = 4,
    parameter int SLOT_W     = 32,
    parameter int SAMPLE_W   = 8,
    parameter int LJ_MODE    = 0,
    parameter int OFFSET_BIN = 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                sd_i,
    output logic                sck_o,
    output logic                ws_o,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int K_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    // Number of sck rises between a ws edge and the sample MSB.
    localparam int D     = (LJ_MODE != 0) ? 0 : 1;

    localparam logic [DIV_W-1:0]    DIV_MAX  = DIV_W'(HALF - 1);
    localparam logic [K_W-1:0]      K_MAX    = K_W'(SLOT_W - 1);
    localparam logic [K_W-1:0]      K_FIRST  = K_W'(D);
    localparam logic [K_W-1:0]      K_LAST   = K_W'(D + SAMPLE_W - 1);
    localparam logic [K_W-1:0]      K_SPAN   = K_W'(SAMPLE_W - 1);
    localparam logic [SAMPLE_W-1:0] MSB_MASK = SAMPLE_W'(1) << (SAMPLE_W - 1);
    // XOR applied on output load: flips the MSB for offset-binary output.
    localparam logic [SAMPLE_W-1:0] OUT_XOR  = (OFFSET_BIN != 0) ? MSB_MASK : '0;

    logic [DIV_W-1:0]    div_q, div_d;
    logic                sck_q, sck_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                ws_q, ws_d;
    logic [SAMPLE_W-1:0] left_sh_q, left_sh_d;
    logic [SAMPLE_W-1:0] right_sh_q, right_sh_d;
    logic                frame_done_q, frame_done_d;
    logic [SAMPLE_W-1:0] out_left_q, out_left_d;
    logic [SAMPLE_W-1:0] out_right_q, out_right_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                rise;
    logic [K_W-1:0]      k_off;
    logic                accept;
    logic                load;

    // Bus timing: half-period divider, bit clock, slot counter, word select.
    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        k_d   = k_q;
        ws_d  = ws_q;
        tick  = 1'b0;
        if (en) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                tick  = 1'b1;
                sck_d = ~sck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
            // Fall edge: advance the slot position, swap slots at wrap.
            if (tick && sck_q) begin
                if (k_q == K_MAX) begin
                    k_d  = '0;
                    ws_d = ~ws_q;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
        end else begin
            div_d = '0;
            sck_d = 1'b0;
            k_d   = '0;
            ws_d  = 1'b0;
        end
        rise = tick && !sck_q;
    end

    // Capture: shift sd_i into the active slot on rises inside the sample window.
    always_comb begin
        left_sh_d    = left_sh_q;
        right_sh_d   = right_sh_q;
        frame_done_d = 1'b0;
        // Wraps to a large value for k < K_FIRST, so one compare covers both ends.
        k_off        = k_q - K_FIRST;
        if (!en) begin
            left_sh_d  = '0;
            right_sh_d = '0;
        end else if (rise && (k_off <= K_SPAN)) begin
            if (ws_q) begin
                right_sh_d = SAMPLE_W'({right_sh_q, sd_i});
            end else begin
                left_sh_d = SAMPLE_W'({left_sh_q, sd_i});
            end
            frame_done_d = ws_q && (k_q == K_LAST);
        end
    end

    // Output holding register and handshake.
    // valid/ready: out_valid rises only with freshly loaded data, and data and
    // out_valid hold until a cycle with out_valid && out_ready; that cycle may
    // also load the next frame, so out_valid can stay high with no bubble.
    // A frame completing while the held frame is not being accepted is dropped
    // and sets the sticky overrun flag, which wins over a coincident clear.
    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        accept      = out_valid_q && out_ready;
        load        = frame_done_q && (!out_valid_q || out_ready);
        if (accept) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_left_d  = left_sh_q ^ OUT_XOR;
            out_right_d = right_sh_q ^ OUT_XOR;
            out_valid_d = 1'b1;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (frame_done_q && !load) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q        <= '0;
            sck_q        <= 1'b0;
            k_q          <= '0;
            ws_q         <= 1'b0;
            left_sh_q    <= '0;
            right_sh_q   <= '0;
            frame_done_q <= 1'b0;
            out_left_q   <= OUT_XOR;
            out_right_q  <= OUT_XOR;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            sck_q        <= sck_d;
            k_q          <= k_d;
            ws_q         <= ws_d;
            left_sh_q    <= left_sh_d;
            right_sh_q   <= right_sh_d;
            frame_done_q <= frame_done_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sck_o     = sck_q;
    assign ws_o      = ws_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_team_06_i2s_stereo_rx.sv
// Directed bench for team_06_i2s_stereo_rx: default I2S instance plus a
// left-justified 12-bit instance, each fed by a small ADC model that tracks
// sck/ws falls and drives sd_i for the following rise.
module tb_team_06_i2s_stereo_rx;

    logic clk = 1'b0;
    logic nrst, en0, en1, sd0, sd1, rdy0, rdy1, clr0, clr1;
    logic sck0, ws0, v0, ovr0, sck1, ws1, v1, ovr1;
    logic [7:0]  l0, r0;
    logic [11:0] l1, r1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;

    // ADC model state, index 0 = default instance, 1 = LJ instance
    int          pos  [2];
    logic        pws  [2];
    logic [15:0] tx_l [2];
    logic [15:0] tx_r [2];
    int          mw   [2];
    int          md   [2];

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    team_06_i2s_stereo_rx dut0 (
        .clk(clk), .nrst(nrst), .en(en0), .sd_i(sd0), .sck_o(sck0), .ws_o(ws0),
        .out_left(l0), .out_right(r0), .out_valid(v0), .out_ready(rdy0),
        .overrun(ovr0), .overrun_clr(clr0)
    );

    team_06_i2s_stereo_rx #(
        .CLK_DIV(4), .SLOT_W(16), .SAMPLE_W(12), .LJ_MODE(1), .OFFSET_BIN(0)
    ) dut1 (
        .clk(clk), .nrst(nrst), .en(en1), .sd_i(sd1), .sck_o(sck1), .ws_o(ws1),
        .out_left(l1), .out_right(r1), .out_valid(v1), .out_ready(rdy1),
        .overrun(ovr1), .overrun_clr(clr1)
    );

    // ---------------- ADC model ----------------
    task automatic adc_update(input int idx, input logic ws_now, input logic start);
        int b;
        logic [15:0] w;
        logic bit_v;
        if (start || ws_now != pws[idx]) begin
            pos[idx] = 0;
            pws[idx] = ws_now;
        end else begin
            pos[idx] = pos[idx] + 1;
        end
        b = pos[idx] - md[idx];
        w = ws_now ? tx_r[idx] : tx_l[idx];
        if (b >= 0 && b < mw[idx]) bit_v = w[mw[idx] - 1 - b];
        else bit_v = 1'($urandom_range(0, 1));
        if (idx == 0) sd0 = bit_v;
        else sd1 = bit_v;
    endtask

    always @(negedge sck0) if (en0 && nrst) begin #1; adc_update(0, ws0, 1'b0); end
    always @(posedge en0 or posedge nrst) adc_update(0, 1'b0, 1'b1);
    always @(negedge sck1) if (en1 && nrst) begin #1; adc_update(1, ws1, 1'b0); end
    always @(posedge en1 or posedge nrst) adc_update(1, 1'b0, 1'b1);

    // ---------------- driver tasks ----------------
    // Returns 1 time unit after edge n of the current run (edge 1 = first edge with en=1).
    task automatic wait_edge(input int n);
        while (cyc < t0 + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [7:0] l, input logic [7:0] r, input logic rdy);
        @(negedge clk);
        en0 = 1'b0;
        repeat (3) @(negedge clk);
        tx_l[0] = {8'h00, l};
        tx_r[0] = {8'h00, r};
        rdy0 = rdy;
        en0 = 1'b1;
        t0 = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sck0 !== 1'b0) begin failures++; $display("FAIL rst_sck got=%b want=0", sck0); end
        checks++; if (ws0 !== 1'b0) begin failures++; $display("FAIL rst_ws got=%b want=0", ws0); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", v0); end
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b want=0", ovr0); end
        checks++; if (l0 !== 8'h80 || r0 !== 8'h80) begin failures++; $display("FAIL rst_data got=%h/%h want=80/80", l0, r0); end
        checks++; if (l1 !== 12'h000 || r1 !== 12'h000) begin failures++; $display("FAIL rst_data_raw got=%h/%h want=000/000", l1, r1); end
        @(negedge clk);
        nrst = 1'b1;
        en0 = 1'b1;
        t0 = cyc;
        wait_edge(1);
        checks++; if (sck0 !== 1'b0) begin failures++; $display("FAIL rst_sck_e1 got=%b want=0", sck0); end
        wait_edge(2);
        checks++; if (sck0 !== 1'b1) begin failures++; $display("FAIL rst_sck_e2 got=%b want=1", sck0); end
    endtask

    task automatic test_i2s_frame();
        wait_edge(127);
        checks++; if (ws0 !== 1'b0) begin failures++; $display("FAIL i2s_ws_127 got=%b want=0", ws0); end
        wait_edge(128);
        checks++; if (ws0 !== 1'b1) begin failures++; $display("FAIL i2s_ws_128 got=%b want=1", ws0); end
        wait_edge(162);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL i2s_valid_early got=%b want=0", v0); end
        wait_edge(163);
        checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL i2s_valid got=%b want=1", v0); end
        checks++; if (l0 !== 8'h00 || r0 !== 8'hFF) begin failures++; $display("FAIL i2s_data got=%h/%h want=00/ff", l0, r0); end
        wait_edge(164);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL i2s_accept got=%b want=0", v0); end
        wait_edge(255);
        checks++; if (ws0 !== 1'b1) begin failures++; $display("FAIL i2s_ws_255 got=%b want=1", ws0); end
        wait_edge(256);
        checks++; if (ws0 !== 1'b0) begin failures++; $display("FAIL i2s_ws_256 got=%b want=0", ws0); end
        wait_edge(384);
        checks++; if (ws0 !== 1'b1) begin failures++; $display("FAIL i2s_ws_384 got=%b want=1", ws0); end
        wait_edge(419);
        checks++; if (v0 !== 1'b1 || l0 !== 8'h00 || r0 !== 8'hFF) begin failures++; $display("FAIL i2s_frame2 got=%b %h/%h want=1 00/ff", v0, l0, r0); end
    endtask

    task automatic test_lj_mode();
        int n;
        n = 0;
        @(negedge clk);
        en1 = 1'b1;
        while (v1 !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 111) begin failures++; $display("FAIL lj_latency got=%0d want=111", n); end
        checks++; if (l1 !== 12'hA5C) begin failures++; $display("FAIL lj_left got=%h want=a5c", l1); end
        checks++; if (r1 !== 12'h123) begin failures++; $display("FAIL lj_right got=%h want=123", r1); end
        @(negedge clk);
        en1 = 1'b0;
    endtask

    task automatic test_backpressure();
        start_run(8'h10, 8'h20, 1'b0);
        wait_edge(163);
        checks++; if (v0 !== 1'b1 || l0 !== 8'h90 || r0 !== 8'hA0) begin failures++; $display("FAIL bp_frame1 got=%b %h/%h want=1 90/a0", v0, l0, r0); end
        tx_l[0] = 16'h30;
        tx_r[0] = 16'h40;
        wait_edge(418);
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL bp_ovr_early got=%b want=0", ovr0); end
        wait_edge(419);
        checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL bp_ovr got=%b want=1", ovr0); end
        checks++; if (v0 !== 1'b1 || l0 !== 8'h90 || r0 !== 8'hA0) begin failures++; $display("FAIL bp_hold got=%b %h/%h want=1 90/a0", v0, l0, r0); end
        rdy0 = 1'b1;
        wait_edge(420);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b want=0", v0); end
        rdy0 = 1'b0;
        clr0 = 1'b1;
        wait_edge(421);
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL bp_ovr_clr got=%b want=0", ovr0); end
        clr0 = 1'b0;
        tx_l[0] = 16'h50;
        tx_r[0] = 16'h60;
        wait_edge(675);
        checks++; if (v0 !== 1'b1 || l0 !== 8'hD0 || r0 !== 8'hE0) begin failures++; $display("FAIL bp_frame3 got=%b %h/%h want=1 d0/e0", v0, l0, r0); end
        tx_l[0] = 16'h11;
        tx_r[0] = 16'h22;
        wait_edge(930);
        clr0 = 1'b1;
        wait_edge(931);
        checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL bp_clr_vs_drop got=%b want=1", ovr0); end
        checks++; if (l0 !== 8'hD0 || r0 !== 8'hE0) begin failures++; $display("FAIL bp_hold3 got=%h/%h want=d0/e0", l0, r0); end
        clr0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        tx_l[0] = 16'h33;
        tx_r[0] = 16'h44;
        wait_edge(1186);
        checks++; if (v0 !== 1'b1 || l0 !== 8'hD0) begin failures++; $display("FAIL b2b_pre got=%b %h want=1 d0", v0, l0); end
        rdy0 = 1'b1;
        wait_edge(1187);
        checks++; if (v0 !== 1'b1 || l0 !== 8'hB3 || r0 !== 8'hC4) begin failures++; $display("FAIL b2b_load got=%b %h/%h want=1 b3/c4", v0, l0, r0); end
        checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL b2b_ovr got=%b want=1", ovr0); end
        rdy0 = 1'b0;
        wait_edge(1188);
        checks++; if (v0 !== 1'b1 || l0 !== 8'hB3) begin failures++; $display("FAIL b2b_hold got=%b %h want=1 b3", v0, l0); end
        rdy0 = 1'b1;
        wait_edge(1189);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b want=0", v0); end
        clr0 = 1'b1;
        wait_edge(1190);
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL b2b_clr got=%b want=0", ovr0); end
        clr0 = 1'b0;
    endtask

    task automatic test_en_drop();
        int bad_v;
        int bad_bus;
        bad_v = 0;
        bad_bus = 0;
        start_run(8'hAA, 8'h55, 1'b1);
        wait_edge(141);
        checks++; if (ws0 !== 1'b1) begin failures++; $display("FAIL en_pre_ws got=%b want=1", ws0); end
        en0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (v0 !== 1'b0) bad_v++;
            if (sck0 !== 1'b0 || ws0 !== 1'b0) bad_bus++;
        end
        checks++; if (bad_bus !== 0) begin failures++; $display("FAIL en_idle_bus got=%0d want=0", bad_bus); end
        tx_l[0] = 16'h5A;
        tx_r[0] = 16'hC3;
        @(negedge clk);
        en0 = 1'b1;
        t0 = cyc;
        wait_edge(2);
        checks++; if (sck0 !== 1'b1 || ws0 !== 1'b0) begin failures++; $display("FAIL en_restart got=%b/%b want=1/0", sck0, ws0); end
        for (int n = 2; n <= 162; n++) begin
            wait_edge(n);
            if (v0 !== 1'b0) bad_v++;
        end
        checks++; if (bad_v !== 0) begin failures++; $display("FAIL en_partial got=%0d want=0", bad_v); end
        wait_edge(163);
        checks++; if (v0 !== 1'b1 || l0 !== 8'hDA || r0 !== 8'h43) begin failures++; $display("FAIL en_next got=%b %h/%h want=1 da/43", v0, l0, r0); end
    endtask

    task automatic test_reset_mid_frame();
        int bad_v;
        bad_v = 0;
        start_run(8'hAA, 8'h55, 1'b0);
        wait_edge(163);
        checks++; if (v0 !== 1'b1 || l0 !== 8'h2A || r0 !== 8'hD5) begin failures++; $display("FAIL mr_pre got=%b %h/%h want=1 2a/d5", v0, l0, r0); end
        wait_edge(300);
        checks++; if (ws0 !== 1'b0 || v0 !== 1'b1) begin failures++; $display("FAIL mr_left got=%b/%b want=0/1", ws0, v0); end
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0 || ovr0 !== 1'b0) begin failures++; $display("FAIL mr_flags got=%b/%b want=0/0", v0, ovr0); end
        checks++; if (sck0 !== 1'b0 || ws0 !== 1'b0) begin failures++; $display("FAIL mr_bus got=%b/%b want=0/0", sck0, ws0); end
        checks++; if (l0 !== 8'h80 || r0 !== 8'h80) begin failures++; $display("FAIL mr_data got=%h/%h want=80/80", l0, r0); end
        tx_l[0] = 16'h01;
        tx_r[0] = 16'hFE;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 162; n++) begin
            wait_edge(n);
            if (v0 !== 1'b0) bad_v++;
        end
        checks++; if (bad_v !== 0) begin failures++; $display("FAIL mr_partial got=%0d want=0", bad_v); end
        wait_edge(163);
        checks++; if (v0 !== 1'b1 || l0 !== 8'h81 || r0 !== 8'h7E) begin failures++; $display("FAIL mr_next got=%b %h/%h want=1 81/7e", v0, l0, r0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        nrst = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        sd0 = 1'b0;
        sd1 = 1'b0;
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        clr0 = 1'b0;
        clr1 = 1'b0;
        md[0] = 1;
        mw[0] = 8;
        md[1] = 0;
        mw[1] = 12;
        pos[0] = 0;
        pos[1] = 0;
        pws[0] = 1'b0;
        pws[1] = 1'b0;
        tx_l[0] = 16'h80;
        tx_r[0] = 16'h7F;
        tx_l[1] = 16'hA5C;
        tx_r[1] = 16'h123;
        test_reset();
        test_i2s_frame();
        test_lj_mode();
        test_backpressure();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
